// File: rtl/lapido_imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// master = loader side, slave = stream source / memory side.
interface lapido_imem_loader_if #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32
);
   logic [7:0]            in_data;
   logic                  in_valid;
   logic                  in_ready;
   logic                  imem_we;
   logic [ADDR_WIDTH-1:0] imem_addr;
   logic [DATA_WIDTH-1:0] imem_wdata;

   modport master (
      input  in_data, in_valid,
      output in_ready, imem_we, imem_addr, imem_wdata
   );

   modport slave (
      output in_data, in_valid,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/lapido_imem_loader.sv
// Loads a length-prefixed big-endian program into instruction memory; write strobe one cycle after 4th byte.
// Backpressure: in_ready drops outside LEN_HI/LEN_LO/DATA, so the source holds its byte through WRITE/IDLE.
module lapido_imem_loader #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 65535
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   lapido_imem_loader_if.master bus,
   output logic                 core_hold,
   output logic                 done,
   output logic                 error
);
   typedef enum logic [2:0] {
      IDLE, LEN_HI, LEN_LO, DATA, WRITE, DONE, ERROR
   } state_t;

   localparam int          TW  = $clog2(TIMEOUT + 1);
   localparam logic [32:0] CAP = 33'(1) << ADDR_WIDTH;

   state_t         state;
   logic [7:0]     len_hi;
   logic [15:0]    word_len;
   logic [15:0]    word_cnt;
   logic [1:0]     byte_cnt;
   logic [23:0]    shreg;
   logic [TW-1:0]  tmo_cnt;

   logic           accept;
   logic [15:0]    len_full;
   logic [15:0]    word_cnt_nxt;
   logic           tmo_hit;

   assign accept       = bus.in_valid && bus.in_ready;
   assign len_full     = {len_hi, bus.in_data};
   assign word_cnt_nxt = word_cnt + 16'd1;
   // Error fires on the edge that would make the idle count equal TIMEOUT.
   assign tmo_hit      = (tmo_cnt == TW'(TIMEOUT - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state          <= IDLE;
         bus.in_ready   <= 1'b0;
         bus.imem_we    <= 1'b0;
         bus.imem_addr  <= '0;
         bus.imem_wdata <= '0;
         core_hold      <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
         len_hi         <= '0;
         word_len       <= '0;
         word_cnt       <= '0;
         byte_cnt       <= '0;
         shreg          <= '0;
         tmo_cnt        <= '0;
      end else begin
         case (state)
            IDLE, DONE, ERROR: begin
               if (start) begin
                  state         <= LEN_HI;
                  bus.in_ready  <= 1'b1;
                  bus.imem_addr <= '0;
                  core_hold     <= 1'b1;
                  done          <= 1'b0;
                  error         <= 1'b0;
                  word_cnt      <= '0;
                  byte_cnt      <= '0;
                  tmo_cnt       <= '0;
               end
            end

            LEN_HI, LEN_LO, DATA: begin
               if (accept) begin
                  tmo_cnt <= '0;
                  if (state == LEN_HI) begin
                     len_hi <= bus.in_data;
                     state  <= LEN_LO;
                  end else if (state == LEN_LO) begin
                     word_len <= len_full;
                     if (len_full == 16'd0) begin
                        state        <= DONE;
                        bus.in_ready <= 1'b0;
                        core_hold    <= 1'b0;
                        done         <= 1'b1;
                     end else if ({17'd0, len_full} > CAP) begin
                        state        <= ERROR;
                        bus.in_ready <= 1'b0;
                        error        <= 1'b1;
                     end else begin
                        state <= DATA;
                     end
                  end else if (byte_cnt == 2'd3) begin
                     bus.imem_wdata <= DATA_WIDTH'({shreg, bus.in_data});
                     bus.imem_we    <= 1'b1;
                     bus.in_ready   <= 1'b0;
                     byte_cnt       <= '0;
                     state          <= WRITE;
                  end else begin
                     shreg    <= {shreg[15:0], bus.in_data};
                     byte_cnt <= byte_cnt + 2'd1;
                  end
               end else if (tmo_hit) begin
                  state        <= ERROR;
                  bus.in_ready <= 1'b0;
                  error        <= 1'b1;
               end else if (tmo_cnt != TW'(TIMEOUT)) begin
                  tmo_cnt <= tmo_cnt + TW'(1);
               end
            end

            WRITE: begin
               bus.imem_we   <= 1'b0;
               bus.imem_addr <= bus.imem_addr + ADDR_WIDTH'(1);
               word_cnt      <= word_cnt_nxt;
               if (word_cnt_nxt == word_len) begin
                  state     <= DONE;
                  core_hold <= 1'b0;
                  done      <= 1'b1;
               end else begin
                  state        <= DATA;
                  bus.in_ready <= 1'b1;
               end
            end

            default: begin
               state        <= IDLE;
               bus.in_ready <= 1'b0;
               bus.imem_we  <= 1'b0;
               core_hold    <= 1'b1;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_lapido_imem_loader.sv
// Directed bench for lapido_imem_loader: program loads, length bounds, timeout, stalls and async reset.
module tb_lapido_imem_loader;
   localparam int AW = 10;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   logic start;
   logic core_hold, done, error;
   int   total = 0;
   int   bad   = 0;

   logic [AW-1:0] wq_addr[$];
   logic [DW-1:0] wq_data[$];

   lapido_imem_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

   lapido_imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(16)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .bus       (ifc.master),
      .core_hold (core_hold),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Write-port monitor; sampled mid-cycle, away from the active edge.
   always @(negedge clk) begin
      if (ifc.imem_we === 1'b1) begin
         wq_addr.push_back(ifc.imem_addr);
         wq_data.push_back(ifc.imem_wdata);
         chk("ready_low_in_write", 32'(ifc.in_ready), 32'd0);
      end
   end

   // Called at a negedge; returns at the negedge after the edge that took the byte.
   task automatic send_byte(input logic [7:0] b);
      int   n   = 0;
      logic acc = 1'b0;
      ifc.in_data  = b;
      ifc.in_valid = 1'b1;
      while (!acc && n < 100) begin
         acc = ifc.in_ready;
         @(negedge clk);
         n++;
      end
      ifc.in_valid = 1'b0;
      if (!acc) chk("byte_accept_bound", 32'(acc), 32'd1);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      chk({tag, "_in_ready"},   32'(ifc.in_ready),   32'd0);
      chk({tag, "_imem_we"},    32'(ifc.imem_we),    32'd0);
      chk({tag, "_imem_addr"},  32'(ifc.imem_addr),  32'd0);
      chk({tag, "_imem_wdata"}, ifc.imem_wdata,      32'd0);
      chk({tag, "_core_hold"},  32'(core_hold),      32'd1);
      chk({tag, "_done"},       32'(done),           32'd0);
      chk({tag, "_error"},      32'(error),          32'd0);
   endtask

   initial begin
      logic [31:0] w;
      logic [7:0]  b;
      int          errs;
      logic [31:0] words3 [3];

      rst = 1'b0; start = 1'b0; ifc.in_valid = 1'b0; ifc.in_data = 8'h00;
      repeat (2) @(negedge clk);
      check_reset_vals("rst");
      rst = 1'b1;
      @(negedge clk);
      chk("idle_hold", 32'(core_hold), 32'd1);
      chk("idle_ready", 32'(ifc.in_ready), 32'd0);

      // Two-word load, valid held high (including through the start cycle).
      ifc.in_valid = 1'b1; ifc.in_data = 8'h00;
      pulse_start();
      chk("t1_ready_after_start", 32'(ifc.in_ready), 32'd1);
      chk("t1_hold_loading", 32'(core_hold), 32'd1);
      foreach (b_list1[i]) send_byte(b_list1[i]);
      chk("t1_we_after_4th", 32'(ifc.imem_we), 32'd1);
      chk("t1_done_in_write", 32'(done), 32'd0);
      @(negedge clk);
      chk("t1_done", 32'(done), 32'd1);
      chk("t1_hold_released", 32'(core_hold), 32'd0);
      chk("t1_we_dropped", 32'(ifc.imem_we), 32'd0);
      chk("t1_addr_end", 32'(ifc.imem_addr), 32'd2);
      chk("t1_nwrites", 32'(wq_addr.size()), 32'd2);
      if (wq_addr.size() == 2) begin
         chk("t1_addr0", 32'(wq_addr[0]), 32'd0);
         chk("t1_data0", wq_data[0], 32'h24010005);
         chk("t1_addr1", 32'(wq_addr[1]), 32'd1);
         chk("t1_data1", wq_data[1], 32'h00011020);
      end
      wq_addr.delete(); wq_data.delete();

      // Zero-length load.
      pulse_start();
      chk("t2_hold_reasserted", 32'(core_hold), 32'd1);
      chk("t2_done_cleared", 32'(done), 32'd0);
      send_byte(8'h00); send_byte(8'h00);
      chk("t2_done", 32'(done), 32'd1);
      chk("t2_hold", 32'(core_hold), 32'd0);
      chk("t2_addr", 32'(ifc.imem_addr), 32'd0);
      chk("t2_nwrites", 32'(wq_addr.size()), 32'd0);

      // Length 1025 exceeds capacity.
      pulse_start();
      send_byte(8'h04); send_byte(8'h01);
      chk("t3_error", 32'(error), 32'd1);
      chk("t3_hold", 32'(core_hold), 32'd1);
      chk("t3_ready", 32'(ifc.in_ready), 32'd0);
      chk("t3_done", 32'(done), 32'd0);
      repeat (3) @(negedge clk);
      chk("t3_error_sticky", 32'(error), 32'd1);
      chk("t3_nwrites", 32'(wq_addr.size()), 32'd0);

      // Full capacity, 1024 words: address wraps to 0 only after the last write.
      pulse_start();
      chk("t4_error_cleared", 32'(error), 32'd0);
      send_byte(8'h04); send_byte(8'h00);
      for (int i = 0; i < 1024; i++) begin
         w = (32'(i) * 32'h00010001) ^ 32'hA5000000;
         send_byte(w[31:24]); send_byte(w[23:16]); send_byte(w[15:8]); send_byte(w[7:0]);
      end
      @(negedge clk);
      chk("t4_done", 32'(done), 32'd1);
      chk("t4_addr_wrapped", 32'(ifc.imem_addr), 32'd0);
      chk("t4_nwrites", 32'(wq_addr.size()), 32'd1024);
      errs = 0;
      if (wq_addr.size() == 1024)
         for (int i = 0; i < 1024; i++)
            if (wq_addr[i] !== AW'(i) || wq_data[i] !== ((32'(i) * 32'h00010001) ^ 32'hA5000000))
               errs++;
      chk("t4_word_errors", 32'(errs), 32'd0);
      wq_addr.delete(); wq_data.delete();

      // Timeout: stream stops after 2 data bytes; error 16 cycles after last accept.
      pulse_start();
      send_byte(8'h00); send_byte(8'h01); send_byte(8'hAA); send_byte(8'hBB);
      repeat (15) @(negedge clk);
      chk("t5_no_error_at_15", 32'(error), 32'd0);
      @(negedge clk);
      chk("t5_error_at_16", 32'(error), 32'd1);
      chk("t5_hold", 32'(core_hold), 32'd1);
      chk("t5_nwrites", 32'(wq_addr.size()), 32'd0);

      // N=3 with random gaps on in_valid.
      words3[0] = 32'h11223344; words3[1] = 32'hA5A55A5A; words3[2] = 32'h0BADF00D;
      pulse_start();
      send_byte(8'h00); send_byte(8'h03);
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(0, 2)) @(negedge clk);
         w = words3[i / 4];
         b = w[31 - 8 * (i % 4) -: 8];
         send_byte(b);
      end
      @(negedge clk);
      chk("t6_done", 32'(done), 32'd1);
      chk("t6_nwrites", 32'(wq_addr.size()), 32'd3);
      if (wq_addr.size() == 3)
         for (int i = 0; i < 3; i++) begin
            chk("t6_addr", 32'(wq_addr[i]), 32'(i));
            chk("t6_data", wq_data[i], words3[i]);
         end
      wq_addr.delete(); wq_data.delete();

      // Async reset mid-DATA, then reload one word.
      pulse_start();
      send_byte(8'h00); send_byte(8'h02); send_byte(8'h11); send_byte(8'h22);
      #2 rst = 1'b0;
      #1 check_reset_vals("arst");
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      pulse_start();
      send_byte(8'h00); send_byte(8'h01);
      send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
      @(negedge clk);
      chk("t7_done", 32'(done), 32'd1);
      chk("t7_nwrites", 32'(wq_addr.size()), 32'd1);
      if (wq_addr.size() == 1) begin
         chk("t7_addr", 32'(wq_addr[0]), 32'd0);
         chk("t7_data", wq_data[0], 32'hDEADBEEF);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   logic [7:0] b_list1 [10] = '{8'h00, 8'h02, 8'h24, 8'h01, 8'h00, 8'h05, 8'h00, 8'h01, 8'h10, 8'h20};
endmodule
